ram_port_arbiter: RTL

Two-requester arbiter and sequencer for one `single_port_ram`-style synchronous single-port memory. It lets the SPI-side requester (port A) and the datapath-side requester (port B) share the RAM on a per-cycle basis. It issues at most one access per cycle and returns read data to the requester that issued it. Port selection is bounded-burst round-robin, so neither side can starve the other.

---
 rtl/ram_port_arbiter.sv | 129 ++++++++++++
 1 files changed

// File: rtl/ram_port_arbiter.sv
// Two-port arbiter/sequencer for one synchronous single-port RAM.
// Bounded-burst round-robin grants, 1-cycle read return to the issuing port.
module ram_port_arbiter #(
  parameter int MEM_DEPTH  = 8,
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = $clog2(MEM_DEPTH) + 1,
  parameter int MAX_BURST  = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  a_req,
  input  logic                  a_we,
  input  logic [ADDR_WIDTH-1:0] a_addr,
  input  logic [DATA_WIDTH-1:0] a_wdata,
  output logic                  a_gnt,
  output logic                  a_rvalid,
  output logic [DATA_WIDTH-1:0] a_rdata,
  input  logic                  b_req,
  input  logic                  b_we,
  input  logic [ADDR_WIDTH-1:0] b_addr,
  input  logic [DATA_WIDTH-1:0] b_wdata,
  output logic                  b_gnt,
  output logic                  b_rvalid,
  output logic [DATA_WIDTH-1:0] b_rdata,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic                  ram_we,
  output logic                  ram_oe,
  output logic [DATA_WIDTH-1:0] ram_wr_data,
  input  logic [DATA_WIDTH-1:0] ram_rd_data
);

  typedef enum logic [1:0] {IDLE, OWN_A, OWN_B} state_t;

  localparam logic [3:0] BURST_MAX = 4'(MAX_BURST);

  state_t     state;
  logic [3:0] cnt;
  logic       pri;          // 0 selects A, 1 selects B when both request from IDLE
  logic       gnt_a, gnt_b;
  logic       a_vld_p1, b_vld_p1;

  function automatic logic [3:0] sat_inc(input logic [3:0] c);
    return (c >= BURST_MAX) ? BURST_MAX : c + 4'd1;
  endfunction

  // Stage p0: combinational grant and RAM command mux
  always_comb begin
    gnt_a = 1'b0;
    gnt_b = 1'b0;
    case (state)
      OWN_A: begin
        if (a_req && (!b_req || cnt < BURST_MAX)) gnt_a = 1'b1;
        else if (b_req)                           gnt_b = 1'b1;
      end
      OWN_B: begin
        if (b_req && (!a_req || cnt < BURST_MAX)) gnt_b = 1'b1;
        else if (a_req)                           gnt_a = 1'b1;
      end
      default: begin
        if (a_req && (!b_req || !pri)) gnt_a = 1'b1;
        else if (b_req)                gnt_b = 1'b1;
      end
    endcase
    if (!rst_n) begin
      gnt_a = 1'b0;
      gnt_b = 1'b0;
    end
  end

  assign a_gnt = gnt_a;
  assign b_gnt = gnt_b;

  always_comb begin
    ram_addr    = '0;
    ram_we      = 1'b0;
    ram_wr_data = '0;
    if (gnt_a) begin
      ram_addr    = a_addr;
      ram_we      = a_we;
      ram_wr_data = a_wdata;
    end else if (gnt_b) begin
      ram_addr    = b_addr;
      ram_we      = b_we;
      ram_wr_data = b_wdata;
    end
  end

  // Stage p1: ownership/burst state and read-return flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      pri      <= 1'b0;
      a_vld_p1 <= 1'b0;
      b_vld_p1 <= 1'b0;
    end else begin
      a_vld_p1 <= gnt_a & ~a_we;
      b_vld_p1 <= gnt_b & ~b_we;
      if (gnt_a) begin
        if (state == OWN_A) begin
          cnt <= sat_inc(cnt);
        end else begin
          cnt <= 4'd1;
          // B still requesting yet lost the grant: its burst limit expired
          if (state == OWN_B && b_req) pri <= 1'b1;
        end
        state <= OWN_A;
      end else if (gnt_b) begin
        if (state == OWN_B) begin
          cnt <= sat_inc(cnt);
        end else begin
          cnt <= 4'd1;
          if (state == OWN_A && a_req) pri <= 1'b0;
        end
        state <= OWN_B;
      end else if (state != IDLE) begin
        state <= IDLE;
        pri   <= (state == OWN_A);
      end
    end
  end

  assign a_rvalid = a_vld_p1;
  assign b_rvalid = b_vld_p1;
  assign ram_oe   = a_vld_p1 | b_vld_p1;
  assign a_rdata  = a_vld_p1 ? ram_rd_data : '0;
  assign b_rdata  = b_vld_p1 ? ram_rd_data : '0;

endmodule
